// File: rtl/mul_unit.sv
// Iterative shift-add multiplier feeding the accumulator register.
// Optional macro MUL_SIGNED_EN selects two's complement operands.
module mul_unit #(
  parameter int DATA_WIDTH = 11
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mul_start,
  input  logic [DATA_WIDTH-1:0] mul_a,
  input  logic [DATA_WIDTH-1:0] mul_b,
  output logic                  mul_busy,
  output logic                  mul_done,
  output logic                  mul_wr,
  output logic [DATA_WIDTH-1:0] mul_out,
  output logic                  mul_ovf
);

  localparam int W  = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_mcand;
  logic [PW-1:0]   r_prod;
  logic [W-1:0]    r_mplier;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_out;
  logic            r_ovf;

  logic [PW-1:0]   w_prod_nxt;
  logic [W-1:0]    w_op_a;
  logic [W-1:0]    w_op_b;
  logic [W-1:0]    w_res;
  logic            w_ovf;

  // Partial product after the current iteration
  always_comb begin
    w_prod_nxt = r_prod;
    if (r_mplier[0]) begin
      w_prod_nxt = r_prod + r_mcand;
    end
  end

`ifdef MUL_SIGNED_EN
  logic r_neg;

  // Operands enter the datapath as magnitudes
  always_comb begin
    w_op_a = mul_a;
    w_op_b = mul_b;
    if (mul_a[W-1]) begin
      w_op_a = ~mul_a + W'(1);
    end
    if (mul_b[W-1]) begin
      w_op_b = ~mul_b + W'(1);
    end
  end

  // Result sign is fixed when the operation is accepted
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_neg <= 1'b0;
    end else if (r_state == S_IDLE && mul_start) begin
      r_neg <= mul_a[W-1] ^ mul_b[W-1];
    end
  end

  // Negate the magnitude and range-check against the signed W-bit range
  always_comb begin
    w_res = w_prod_nxt[W-1:0];
    w_ovf = |w_prod_nxt[PW-1:W-1];
    if (r_neg) begin
      w_res = ~w_prod_nxt[W-1:0] + W'(1);
      w_ovf = (|w_prod_nxt[PW-1:W])
            | (w_prod_nxt[W-1] & (|w_prod_nxt[W-2:0]));
    end
  end
`else
  // Unsigned: truncate and flag any lost high bit
  always_comb begin
    w_op_a = mul_a;
    w_op_b = mul_b;
    w_res  = w_prod_nxt[W-1:0];
    w_ovf  = |w_prod_nxt[PW-1:W];
  end
`endif

  // Control FSM and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_prod   <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_out    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (mul_start) begin
            r_mcand  <= {{W{1'b0}}, w_op_a};
            r_mplier <= w_op_b;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_prod   <= w_prod_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_out   <= w_res;
            r_ovf   <= w_ovf;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mul_busy = (r_state != S_IDLE);
  assign mul_done = (r_state == S_DONE);
  assign mul_wr   = mul_done;
  assign mul_out  = r_out;
  assign mul_ovf  = r_ovf;

endmodule

// File: tb/tb_mul_unit.sv
// Directed bench for mul_unit at DATA_WIDTH = 11.
// Signed vectors run only when MUL_SIGNED_EN is defined.
module tb_mul_unit;

  localparam int W = 11;

  logic         clock;
  logic         reset;
  logic         mul_start;
  logic [W-1:0] mul_a;
  logic [W-1:0] mul_b;
  logic         mul_busy;
  logic         mul_done;
  logic         mul_wr;
  logic [W-1:0] mul_out;
  logic         mul_ovf;

  int checks = 0;
  int errors = 0;

  mul_unit #(.DATA_WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_busy  (mul_busy),
    .mul_done  (mul_done),
    .mul_wr    (mul_wr),
    .mul_out   (mul_out),
    .mul_ovf   (mul_ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the done pulse; returns edges waited.
  task automatic wait_done(output int n, output int busy_n,
                           output bit held,
                           input logic [W-1:0] prev);
    n      = 0;
    busy_n = int'(mul_busy);
    held   = 1'b1;
    while (!mul_done && n < 40) begin
      @(posedge clock);
      #1;
      n++;
      busy_n += int'(mul_busy);
      if (!mul_done && mul_out !== prev) held = 1'b0;
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic [W-1:0] eo,
                        input logic eovf);
    int n;
    int bn;
    bit held;
    logic [W-1:0] prev;
    @(negedge clock);
    mul_a     = a;
    mul_b     = b;
    mul_start = 1'b1;
    @(posedge clock);
    #1;
    mul_start = 1'b0;
    prev = mul_out;
    wait_done(n, bn, held, prev);
    chk({tag, "_lat"}, n, 11);
    chk({tag, "_out"}, mul_out, eo);
    chk({tag, "_ovf"}, mul_ovf, eovf);
    chk({tag, "_wr"}, mul_wr, 1);
    chk({tag, "_busycnt"}, bn, 12);
    chk({tag, "_held"}, held, 1);
    @(posedge clock);
    #1;
    chk({tag, "_donelow"}, mul_done, 0);
    chk({tag, "_idle"}, mul_busy, 0);
    chk({tag, "_keep"}, mul_out, eo);
  endtask

  initial begin
    int n;
    int bn;
    int pulses;
    bit held;

    reset     = 1'b0;
    mul_start = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", mul_busy, 0);
    chk("rst_done", mul_done, 0);
    chk("rst_wr", mul_wr, 0);
    chk("rst_out", mul_out, 0);
    chk("rst_ovf", mul_ovf, 0);
    @(negedge clock);
    reset = 1'b1;

    run_op("u5x6", 11'd5, 11'd6, 11'd30, 1'b0);
    run_op("u100x30", 11'd100, 11'd30, 11'd952, 1'b1);
    run_op("zero_a", 11'd0, 11'd2047, 11'd0, 1'b0);
    run_op("zero_b", 11'd1234, 11'd0, 11'd0, 1'b0);
    run_op("u1x2047", 11'd1, 11'd2047, 11'd2047, 1'b0);
    run_op("u32x64", 11'd32, 11'd64, 11'd0, 1'b1);
    run_op("umax", 11'd2047, 11'd2047, 11'd1, 1'b1);

    // Start held high; operands change during RUN
    @(negedge clock);
    mul_a     = 11'd7;
    mul_b     = 11'd9;
    mul_start = 1'b1;
    @(posedge clock);
    #1;
    mul_a = 11'd3;
    mul_b = 11'd3;
    wait_done(n, bn, held, mul_out);
    chk("hold1_lat", n, 11);
    chk("hold1_out", mul_out, 63);
    @(posedge clock);
    #1;
    chk("hold_gap_busy", mul_busy, 0);
    chk("hold_gap_done", mul_done, 0);
    @(posedge clock);
    #1;
    mul_start = 1'b0;
    chk("hold2_busy", mul_busy, 1);
    wait_done(n, bn, held, 11'd63);
    chk("hold2_lat", n, 11);
    chk("hold2_out", mul_out, 9);
    chk("hold2_held", held, 1);
    pulses = 0;
    repeat (20) begin
      @(posedge clock);
      #1;
      pulses += int'(mul_done);
    end
    chk("hold_nomore", pulses, 0);

    // Reset in the middle of RUN
    @(negedge clock);
    mul_a     = 11'd10;
    mul_b     = 11'd10;
    mul_start = 1'b1;
    @(posedge clock);
    #1;
    mul_start = 1'b0;
    repeat (5) @(posedge clock);
    #2;
    chk("abort_busy_pre", mul_busy, 1);
    reset = 1'b0;
    #1;
    chk("abort_busy", mul_busy, 0);
    chk("abort_out", mul_out, 0);
    chk("abort_ovf", mul_ovf, 0);
    chk("abort_done", mul_done, 0);
    chk("abort_wr", mul_wr, 0);
    @(negedge clock);
    reset  = 1'b1;
    pulses = 0;
    repeat (15) begin
      @(posedge clock);
      #1;
      pulses += int'(mul_done);
    end
    chk("abort_nopulse", pulses, 0);
    run_op("post_rst", 11'd12, 11'd12, 11'd144, 1'b0);

`ifdef MUL_SIGNED_EN
    run_op("sm3x5", 11'd2045, 11'd5, 11'd2033, 1'b0);
    run_op("smin_m1", 11'd1024, 11'd2047, 11'd1024, 1'b1);
    run_op("smin_p1", 11'd1024, 11'd1, 11'd1024, 1'b0);
    run_op("sm32sq", 11'd2016, 11'd2016, 11'd1024, 1'b1);
    run_op("s_neg0", 11'd2045, 11'd0, 11'd0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
